// File: rtl/alu_issue_if.sv
// Bundles the command, ALU drive and response signals of alu_issue.
// master: the side issuing commands, hosting the ALU and taking responses.
// slave:  the issue block itself.
interface alu_issue_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [DATA_WIDTH-1:0] cmd_a;
  logic [DATA_WIDTH-1:0] cmd_b;
  logic                  cmd_dir;
  logic                  cmd_bypass_a;
  logic                  cmd_bypass_b;

  logic [2:0]            alu_op;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic                  alu_dir;
  logic                  alu_bypass_a;
  logic                  alu_bypass_b;
  logic [DATA_WIDTH-1:0] alu_result;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [7:0]            rsp_seq;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_dir, cmd_bypass_a, cmd_bypass_b,
    input  cmd_ready,
    input  alu_op, alu_a, alu_b, alu_dir, alu_bypass_a, alu_bypass_b,
    output alu_result,
    input  rsp_valid, rsp_data, rsp_seq,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_dir, cmd_bypass_a, cmd_bypass_b,
    output cmd_ready,
    output alu_op, alu_a, alu_b, alu_dir, alu_bypass_a, alu_bypass_b,
    input  alu_result,
    output rsp_valid, rsp_data, rsp_seq,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: queues ALU commands in a small FIFO, issues one at a time to an
// external combinational ALU through registered drives, captures the result
// one cycle later and returns it with an 8-bit sequence number.
// Optional feature: define ALU_ISSUE_STATS_EN to add the saturating
// stat_issued / stat_stall counters and their output ports.
module alu_issue #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  bus
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0] stat_issued,
  output logic [15:0] stat_stall
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  dir;
    logic                  bypass_a;
    logic                  bypass_b;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_e;

  state_e                state_q, state_d;
  cmd_t                  fifo_q [DEPTH];
  cmd_t                  cmd_in;
  cmd_t                  alu_q;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full, empty, push, pop, capture, release_rsp;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [7:0]            rsp_seq_q;

  assign cmd_in = {bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_dir,
                   bus.cmd_bypass_a, bus.cmd_bypass_b};

  assign full          = (count_q == CNT_W'(DEPTH));
  assign empty         = (count_q == '0);
  assign bus.cmd_ready = !full && rst_n;
  assign push          = bus.cmd_valid && bus.cmd_ready;

  // Issue sequencing: pop into the ALU drives, wait one cycle, hold the result.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          release_rsp = 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            state_d = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Command storage; push is already blocked while reset is low.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= cmd_in;
    end
  end

  // State, occupancy and pointers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // ALU drive registers and the response holding registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_seq_q   <= '0;
    end else begin
      if (pop) begin
        alu_q <= fifo_q[rd_ptr_q];
      end
      if (capture) begin
        rsp_data_q  <= bus.alu_result;
        rsp_valid_q <= 1'b1;
      end else if (release_rsp) begin
        rsp_valid_q <= 1'b0;
        rsp_seq_q   <= rsp_seq_q + 8'd1;
      end
    end
  end

  assign bus.alu_op       = alu_q.op;
  assign bus.alu_a        = alu_q.a;
  assign bus.alu_b        = alu_q.b;
  assign bus.alu_dir      = alu_q.dir;
  assign bus.alu_bypass_a = alu_q.bypass_a;
  assign bus.alu_bypass_b = alu_q.bypass_b;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_seq      = rsp_seq_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_issued_q, stat_stall_q;

  // Saturating counters of issued commands and of stalled response cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (pop && (stat_issued_q != 16'hFFFF)) begin
        stat_issued_q <= stat_issued_q + 16'd1;
      end
      if (rsp_valid_q && !bus.rsp_ready && (stat_stall_q != 16'hFFFF)) begin
        stat_stall_q <= stat_stall_q + 16'd1;
      end
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the operand/result width and match the downstream ALU.
REQ-002 Parameter DEPTH, default 4, SHALL set the command FIFO entry count (power of two, >=2).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be a synchronous, active-low reset.
REQ-005 cmd_valid/cmd_ready  input/output  1/1  SHALL be the command handshake; transfer when both high at a clock edge.
REQ-006 cmd_op[2:0], cmd_a, cmd_b [DATA_WIDTH-1:0], cmd_dir, cmd_bypass_a, cmd_bypass_b  input  SHALL be the command payload.
REQ-007 alu_op[2:0], alu_a, alu_b, alu_dir, alu_bypass_a, alu_bypass_b  output  SHALL be registered drives into the ALU's op/a/b/dir/bypass inputs.
REQ-008 alu_result  input  DATA_WIDTH  SHALL be the ALU combinational result.
REQ-009 rsp_valid/rsp_ready  output/input  1/1  SHALL be the response handshake.
REQ-010 rsp_data  output  DATA_WIDTH  SHALL carry the captured result; rsp_seq  output  8  SHALL carry its sequence number.

Function
REQ-011 cmd_ready SHALL equal (fifo_count != DEPTH) AND rst_n; no pass-through when full.
REQ-012 FIFO SHALL be first-in first-out; pointers wrap modulo DEPTH; push and pop in the same edge SHALL leave the count unchanged.
REQ-013 FSM states SHALL be IDLE, DRIVE, RESP.
REQ-014 IDLE: if FIFO non-empty, pop at the edge, load the alu_* registers from the head entry, go to DRIVE; else stay.
REQ-015 DRIVE: SHALL last exactly one cycle; at its closing edge capture alu_result into rsp_data, set rsp_valid=1, go to RESP.
REQ-016 RESP: rsp_data/rsp_seq SHALL be held stable while rsp_valid && !rsp_ready.
REQ-017 RESP with rsp_ready=1: clear rsp_valid, increment rsp_seq (wraps 255->0); if FIFO non-empty pop and go to DRIVE in the same edge, else go to IDLE.
REQ-018 Command accepted at edge k into an empty, idle block SHALL yield rsp_valid at edge k+2; sustained throughput 1 result per 2 cycles.
REQ-019 At most one command SHALL be in flight; total capacity DEPTH queued + 1 in flight.
REQ-020 alu_* outputs SHALL hold their last values in IDLE and RESP; op 3'b111 SHALL be forwarded unaltered.

Reset
REQ-021 With rst_n low at an edge: state=IDLE, fifo_count=0, pointers=0, rsp_valid=0, rsp_data=0, rsp_seq=0, all alu_* outputs=0.
REQ-022 Reset in DRIVE or RESP SHALL discard the in-flight command and all queued commands; no response produced.

Configuration
REQ-023 With ALU_ISSUE_STATS_EN defined, outputs stat_issued[15:0] (increments per FIFO pop) and stat_stall[15:0] (increments per cycle rsp_valid && !rsp_ready) SHALL exist, saturate at 16'hFFFF and reset to 0.
REQ-024 Without ALU_ISSUE_STATS_EN, those ports and counters SHALL be absent; all other behaviour identical.

Verification (DATA_WIDTH=8, DEPTH=4, ALU connected)
REQ-025 Push op=3'b011 a=8'h05 b=8'h03 at edge k, rsp_ready=1 -> rsp_valid at edge k+2, rsp_data=8'h08, rsp_seq=0.
REQ-026 Push 6 commands back-to-back, rsp_ready=0 -> 5 accepted, cmd_ready low from then on; release rsp_ready -> 5 responses in push order, rsp_seq 0..4.
REQ-027 Hold rsp_ready=0 for 10 cycles on result 8'hA5 -> rsp_data stays 8'hA5; with stats, stat_stall=10.
REQ-028 op=3'b100 a=8'h10 b=8'h22 bypass_b=1 -> rsp_data=8'h22.
REQ-029 Assert rst_n=0 for one edge during DRIVE with 3 queued -> next cycle rsp_valid=0, cmd_ready=1, no further responses; next response carries rsp_seq=0.
REQ-030 Push 256 commands, rsp_ready=1 -> rsp_seq wraps 8'hFF->8'h00; with stats, stat_issued=256.
